// File: rtl/cpu_mem_pkg.sv
// Shared constants for the CPU data-memory controller: default address map,
// MMIO register offsets and ERR_STATUS bit positions.
package cpu_mem_pkg;

  localparam logic [31:0] DEF_BASE_ADDR   = 32'h0000_1000;
  localparam logic [31:0] DEF_MMIO_BASE   = 32'h0000_2000;
  localparam int          DEF_DEPTH_WORDS = 1024;

  localparam logic [31:0] OFF_LED        = 32'h0000_0000;
  localparam logic [31:0] OFF_CYCLE      = 32'h0000_0004;
  localparam logic [31:0] OFF_STORES     = 32'h0000_0008;
  localparam logic [31:0] OFF_ERR_STATUS = 32'h0000_000C;
  localparam logic [31:0] OFF_ERR_ADDR   = 32'h0000_0010;
  localparam logic [31:0] MMIO_SPAN      = 32'h0000_0014;

  localparam int ERR_MISALIGN = 0;
  localparam int ERR_UNMAPPED = 1;
  localparam int ERR_W        = 2;
  localparam int LED_W        = 10;

endpackage

// File: rtl/data_ram.sv
// Word-addressed data RAM: asynchronous read, synchronous write, no reset.
module data_ram #(
  parameter  int DEPTH_WORDS = 1024,
  localparam int AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_ctrl.sv
// CPU data-memory controller: decodes RAM / MMIO / unmapped regions, owns the
// LED, cycle and store counters, and latches store error status and address.
module data_mem_ctrl
  import cpu_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int          DEPTH_WORDS = DEF_DEPTH_WORDS,
  parameter logic [31:0] MMIO_BASE   = DEF_MMIO_BASE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      Addres,
  input  logic [31:0]      WriteData,
  input  logic             MemWrite,
  output logic [31:0]      readData,
  output logic [LED_W-1:0] led,
  output logic             irq_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [31:0]      ram_word;
  logic [31:0]      mmio_off;
  logic             in_ram;
  logic             in_mmio;
  logic             aligned;
  logic             ram_we;
  logic             mmio_we;
  logic [31:0]      ram_rdata;
  logic [31:0]      mmio_rdata;
  logic [31:0]      cycle_cnt;
  logic [31:0]      store_cnt;
  logic [31:0]      err_addr;
  logic [ERR_W-1:0] err_status;
  logic [ERR_W-1:0] err_set;
  logic [ERR_W-1:0] err_clr;

  assign ram_word = (Addres - BASE_ADDR) >> 2;
  assign mmio_off = Addres - MMIO_BASE;
  assign in_ram   = (Addres >= BASE_ADDR) && (ram_word < 32'(DEPTH_WORDS));
  assign in_mmio  = !in_ram && (Addres >= MMIO_BASE) && (mmio_off < MMIO_SPAN);
  assign aligned  = (Addres[1:0] == 2'b00);

  // Gating with rst keeps a store that coincides with reset out of the unreset array.
  assign ram_we  = MemWrite && aligned && in_ram && rst;
  assign mmio_we = MemWrite && aligned && in_mmio;

  data_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_word[AW-1:0]),
    .wdata(WriteData),
    .rdata(ram_rdata)
  );

  always_comb begin
    err_set = '0;
    err_clr = '0;
    if (MemWrite) begin
      if (!aligned)                 err_set[ERR_MISALIGN] = 1'b1;
      else if (!in_ram && !in_mmio) err_set[ERR_UNMAPPED] = 1'b1;
    end
    if (mmio_we && (mmio_off == OFF_ERR_STATUS)) err_clr = WriteData[ERR_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led        <= '0;
      cycle_cnt  <= '0;
      store_cnt  <= '0;
      err_status <= '0;
      err_addr   <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (ram_we && (store_cnt != '1)) store_cnt <= store_cnt + 32'd1;
      if (mmio_we && (mmio_off == OFF_LED)) led <= WriteData[LED_W-1:0];
      // Set is OR'd after the clear so a simultaneous new error always survives.
      err_status <= (err_status & ~err_clr) | err_set;
      if ((err_set != '0) && (err_status == '0)) err_addr <= Addres;
    end
  end

  assign irq_err = |err_status;

  always_comb begin
    mmio_rdata = '0;
    case (mmio_off)
      OFF_LED:        mmio_rdata = {{(32-LED_W){1'b0}}, led};
      OFF_CYCLE:      mmio_rdata = cycle_cnt;
      OFF_STORES:     mmio_rdata = store_cnt;
      OFF_ERR_STATUS: mmio_rdata = {{(32-ERR_W){1'b0}}, err_status};
      OFF_ERR_ADDR:   mmio_rdata = err_addr;
      default:        mmio_rdata = '0;
    endcase
  end

  always_comb begin
    readData = '0;
    if (in_ram)       readData = ram_rdata;
    else if (in_mmio) readData = mmio_rdata;
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_1000, byte address of RAM word 0.
REQ-002 Parameter DEPTH_WORDS, default 1024, number of 32-bit RAM words.
REQ-003 Parameter MMIO_BASE, default 32'h0000_2000, byte address of the first MMIO register.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 Addres  input  32  byte address driven by the CPU.
REQ-007 WriteData  input  32  store data from the CPU.
REQ-008 MemWrite  input  1  store strobe; one store is accepted per cycle while high.
REQ-009 readData  output  32  load data returned to the CPU, combinational from Addres.
REQ-010 led  output  10  LED register contents.
REQ-011 irq_err  output  1  high while any ERR_STATUS bit is set.

Function
REQ-012 Address decode SHALL have three regions.
- RAM: BASE_ADDR <= Addres < BASE_ADDR+4*DEPTH_WORDS; word index = (Addres-BASE_ADDR)>>2.
- MMIO: MMIO_BASE..MMIO_BASE+0x10.
- Unmapped: all other addresses.
REQ-013 RAM reads SHALL be combinational, with zero-cycle latency; readData = word at the index.
REQ-014 RAM stores SHALL commit on the rising edge when MemWrite=1, Addres is in RAM and Addres[1:0]=0; the new data is visible on readData in the next cycle.
REQ-015 MMIO map (offsets from MMIO_BASE) SHALL be as follows.
- 0x00 LED: RW; bits 9:0 used; upper bits read as 0.
- 0x04 CYCLE: RO; free-running 32-bit counter; +1 every cycle; wraps FFFFFFFF->0.
- 0x08 STORES: RO; count of committed RAM stores; saturates at FFFFFFFF.
- 0x0C ERR_STATUS: RW1C; bit0 misaligned store, bit1 unmapped store.
- 0x10 ERR_ADDR: RO; Addres of the first error captured while ERR_STATUS was 0.
REQ-016 Reads of unmapped addresses, or of unused MMIO offsets, SHALL return 32'h0000_0000.
REQ-017 A store with Addres[1:0]!=0 to any region SHALL be dropped and SHALL set ERR_STATUS bit0.
REQ-018 An aligned store to an unmapped address SHALL be dropped and SHALL set ERR_STATUS bit1.
REQ-019 Stores to CYCLE, STORES or ERR_ADDR SHALL be ignored without raising an error.
REQ-020 ERR_ADDR SHALL update only on the cycle an error sets a bit while ERR_STATUS==0; later errors SHALL NOT overwrite it until ERR_STATUS is fully cleared.
REQ-021 If a W1C clear and a new error hit the same bit in one cycle, set SHALL win.
REQ-022 The address BASE_ADDR+4*DEPTH_WORDS is unmapped (upper-bound boundary).
REQ-023 irq_err SHALL equal |ERR_STATUS, registered, with no extra latency beyond the status flop.
REQ-024 Loads SHALL have no side effects; MemWrite=0 SHALL leave all state unchanged except CYCLE.

Reset
REQ-025 When rst=0, the following SHALL clear immediately and asynchronously: LED, CYCLE, STORES, ERR_STATUS and ERR_ADDR to 0, and therefore led=0 and irq_err=0.
REQ-026 RAM contents SHALL NOT be reset; a store in the same cycle as reset assertion SHALL be discarded.
REQ-027 After rst deasserts, CYCLE SHALL read 0 in the first cycle and then increment.

Structure
REQ-028 Package cpu_mem_pkg SHALL hold the MMIO offset constants, the ERR_STATUS bit indices and the default base addresses.
REQ-029 Sub-module data_ram SHALL hold the RAM array: combinational read port, synchronous write port, parameterised by DEPTH_WORDS; decode, counters and MMIO stay in data_mem_ctrl.

Verification
REQ-030 The bench SHALL cover these directed scenarios.
- Store 32'd4 to 0x0000_1000, then read 0x0000_1000 -> readData=4; STORES=1.
- Store to 0x0000_1002 -> RAM unchanged; ERR_STATUS=1; ERR_ADDR=0x0000_1002; irq_err=1 next cycle.
- Store to 0x0000_3000, then store to 0x0000_1001 -> ERR_STATUS=3; ERR_ADDR=0x0000_3000. Write 1 to 0x200C -> ERR_STATUS=2; write 2 -> irq_err=0.
- Store 32'hFFFF_FFFF to 0x2000 -> led=10'h3FF; read 0x2000 -> 32'h0000_03FF. Store to 0x2004 -> CYCLE keeps counting.
- Assert rst mid-run with a store pending -> led, counters and irq_err=0 immediately; the pending store is not committed. Wait N cycles after release -> CYCLE=N-1.
- Store to the last word (BASE_ADDR+4*(DEPTH_WORDS-1)) -> committed; store to BASE_ADDR+4*DEPTH_WORDS -> ERR_STATUS bit1 set.
